// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target: FSM state encoding and bus constants.
package i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK_ADDR,
        ST_RX_BYTE,
        ST_ACK_RX,
        ST_TX_BYTE,
        ST_ACK_TX,
        ST_WAIT_STOP
    } state_t;

    localparam logic [6:0] GCALL_ADDR = 7'h00;
    localparam logic       ACK        = 1'b0;
    localparam logic       NACK       = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with one extra register stage for edge, START and STOP detection.
module i2c_bus_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_in,
    input  logic sda_in,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_s
);

    logic [SYNC_STAGES-1:0] scl_sh;
    logic [SYNC_STAGES-1:0] sda_sh;
    logic                   scl_d;
    logic                   sda_d;
    logic                   scl_s;

    // Idle bus level is high, so every stage resets to 1 to avoid a phantom edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sh <= '1;
            sda_sh <= '1;
            scl_d  <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_sh <= {scl_sh[SYNC_STAGES-2:0], scl_in};
            sda_sh <= {sda_sh[SYNC_STAGES-2:0], sda_in};
            scl_d  <= scl_s;
            sda_d  <= sda_s;
        end
    end

    assign scl_s     = scl_sh[SYNC_STAGES-1];
    assign sda_s     = sda_sh[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_target.sv
// I2C target with fixed 7-bit address, 1/2-byte write capture and 1/2-byte read return.
// Optional general-call support (and the gcall port) with I2C_TARGET_GCALL_EN.
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDR        = 7'h42,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out,
    input  logic [15:0] tx_data,
    input  logic        tx_two_bytes,
    output logic [15:0] rx_data,
    output logic        rx_two_bytes,
    output logic        rx_valid,
    output logic        busy,
    output logic        addressed
`ifdef I2C_TARGET_GCALL_EN
    ,
    output logic        gcall
`endif
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_s;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_in    (scl_in),
        .sda_in    (sda_in),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_s     (sda_s)
    );

    state_t      state, state_n;
    logic [2:0]  bit_cnt, bit_cnt_n;
    logic        byte_done, byte_done_n;
    logic [7:0]  shreg, shreg_n;
    logic        rw, rw_n;
    logic [15:0] tx_hold, tx_hold_n;
    logic        tx_more, tx_more_n;
    logic [7:0]  txb, txb_n;
    logic [1:0]  rx_cnt, rx_cnt_n;
    logic        sda_q, sda_n;
    logic [15:0] rx_data_n;
    logic        rx_two_n, rx_valid_n, busy_n, addressed_n;
    logic        is_gcall, addr_match;
    logic [7:0]  tx_first;

`ifdef I2C_TARGET_GCALL_EN
    logic gcall_q, gcall_n;
    assign is_gcall = (shreg[7:1] == GCALL_ADDR) && (shreg[0] == 1'b0);
    assign gcall    = gcall_q;
`else
    assign is_gcall = 1'b0;
`endif

    assign addr_match = (shreg[7:1] == ADDR) || is_gcall;
    // tx_more set means the low byte is still pending, so the high byte goes first.
    assign tx_first   = tx_more ? tx_hold[15:8] : tx_hold[7:0];
    // Bus conditions release SDA combinationally, ahead of the registered update.
    assign sda_out    = sda_q | start_det | stop_det;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= 3'd7;
            byte_done    <= 1'b0;
            shreg        <= '0;
            rw           <= 1'b0;
            tx_hold      <= '0;
            tx_more      <= 1'b0;
            txb          <= '1;
            rx_cnt       <= '0;
            sda_q        <= 1'b1;
            rx_data      <= '0;
            rx_two_bytes <= 1'b0;
            rx_valid     <= 1'b0;
            busy         <= 1'b0;
            addressed    <= 1'b0;
`ifdef I2C_TARGET_GCALL_EN
            gcall_q      <= 1'b0;
`endif
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            byte_done    <= byte_done_n;
            shreg        <= shreg_n;
            rw           <= rw_n;
            tx_hold      <= tx_hold_n;
            tx_more      <= tx_more_n;
            txb          <= txb_n;
            rx_cnt       <= rx_cnt_n;
            sda_q        <= sda_n;
            rx_data      <= rx_data_n;
            rx_two_bytes <= rx_two_n;
            rx_valid     <= rx_valid_n;
            busy         <= busy_n;
            addressed    <= addressed_n;
`ifdef I2C_TARGET_GCALL_EN
            gcall_q      <= gcall_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        byte_done_n = byte_done;
        shreg_n     = shreg;
        rw_n        = rw;
        tx_hold_n   = tx_hold;
        tx_more_n   = tx_more;
        txb_n       = txb;
        rx_cnt_n    = rx_cnt;
        sda_n       = sda_q;
        rx_data_n   = rx_data;
        rx_two_n    = rx_two_bytes;
        rx_valid_n  = 1'b0;
        busy_n      = busy;
        addressed_n = addressed;
`ifdef I2C_TARGET_GCALL_EN
        gcall_n     = gcall_q;
`endif

        if (start_det || stop_det) begin
            if (rx_cnt != 2'd0) begin
                rx_valid_n = 1'b1;
                rx_two_n   = (rx_cnt == 2'd2);
            end
            rx_cnt_n    = '0;
            sda_n       = NACK;
            addressed_n = 1'b0;
            bit_cnt_n   = 3'd7;
            byte_done_n = 1'b0;
`ifdef I2C_TARGET_GCALL_EN
            gcall_n     = 1'b0;
`endif
            if (start_det) begin
                state_n = ST_ADDR;
                busy_n  = 1'b1;
            end else begin
                state_n = ST_IDLE;
                busy_n  = 1'b0;
            end
        end else begin
            case (state)
                ST_ADDR, ST_RX_BYTE: begin
                    if (scl_rise && !byte_done) begin
                        shreg_n = {shreg[6:0], sda_s};
                        if (bit_cnt == 3'd0) byte_done_n = 1'b1;
                        else                 bit_cnt_n   = bit_cnt - 3'd1;
                    end else if (scl_fall && byte_done) begin
                        byte_done_n = 1'b0;
                        bit_cnt_n   = 3'd7;
                        if (state == ST_ADDR) begin
                            if (addr_match) begin
                                state_n     = ST_ACK_ADDR;
                                sda_n       = ACK;
                                addressed_n = 1'b1;
                                rw_n        = shreg[0];
                                tx_hold_n   = tx_data;
                                tx_more_n   = tx_two_bytes;
`ifdef I2C_TARGET_GCALL_EN
                                gcall_n     = is_gcall;
`endif
                            end else begin
                                state_n = ST_WAIT_STOP;
                                sda_n   = NACK;
                            end
                        end else if (rx_cnt != 2'd2) begin
                            state_n   = ST_ACK_RX;
                            sda_n     = ACK;
                            rx_data_n = {rx_data[7:0], shreg};
                            rx_cnt_n  = rx_cnt + 2'd1;
                        end else begin
                            state_n = ST_WAIT_STOP;
                            sda_n   = NACK;
                        end
                    end
                end
                ST_ACK_ADDR: begin
                    if (scl_fall) begin
                        if (rw) begin
                            state_n = ST_TX_BYTE;
                            txb_n   = tx_first;
                            sda_n   = tx_first[7];
                        end else begin
                            state_n = ST_RX_BYTE;
                            sda_n   = NACK;
                        end
                    end
                end
                ST_ACK_RX: begin
                    if (scl_fall) begin
                        state_n = ST_RX_BYTE;
                        sda_n   = NACK;
                    end
                end
                ST_TX_BYTE: begin
                    if (scl_rise && !byte_done) begin
                        if (bit_cnt == 3'd0) byte_done_n = 1'b1;
                        else                 bit_cnt_n   = bit_cnt - 3'd1;
                    end else if (scl_fall) begin
                        if (byte_done) begin
                            state_n     = ST_ACK_TX;
                            sda_n       = NACK;
                            byte_done_n = 1'b0;
                        end else begin
                            sda_n = txb[bit_cnt];
                        end
                    end
                end
                ST_ACK_TX: begin
                    if (scl_rise && !byte_done) begin
                        shreg_n     = {shreg[6:0], sda_s};
                        byte_done_n = 1'b1;
                    end else if (scl_fall && byte_done) begin
                        byte_done_n = 1'b0;
                        bit_cnt_n   = 3'd7;
                        if (shreg[0] == ACK) begin
                            state_n = ST_TX_BYTE;
                            if (tx_more) begin
                                txb_n     = tx_hold[7:0];
                                tx_more_n = 1'b0;
                                sda_n     = tx_hold[7];
                            end else begin
                                txb_n = 8'hFF;
                                sda_n = NACK;
                            end
                        end else begin
                            state_n = ST_WAIT_STOP;
                            sda_n   = NACK;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged bus master, rx_valid monitor, hand-computed expectations.
module tb_i2c_target;

    localparam int unsigned Q = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_out;
    logic        sda_line;
    logic [15:0] tx_data = '0;
    logic        tx_two_bytes = 1'b0;
    logic [15:0] rx_data;
    logic        rx_two_bytes, rx_valid, busy, addressed;
`ifdef I2C_TARGET_GCALL_EN
    logic        gcall;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned vcnt = 0;
    logic [15:0] cap_data = '0;
    logic        cap_two = 1'b0;

    assign sda_line = sda_m & sda_out;

    i2c_target #(.ADDR(7'h42), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .scl_in       (scl),
        .sda_in       (sda_line),
        .sda_out      (sda_out),
        .tx_data      (tx_data),
        .tx_two_bytes (tx_two_bytes),
        .rx_data      (rx_data),
        .rx_two_bytes (rx_two_bytes),
        .rx_valid     (rx_valid),
        .busy         (busy),
        .addressed    (addressed)
`ifdef I2C_TARGET_GCALL_EN
        ,
        .gcall        (gcall)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            vcnt     = vcnt + 1;
            cap_data = rx_data;
            cap_two  = rx_two_bytes;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        if (!scl) begin
            sda_m = 1'b1; wait_clk(Q);
            scl   = 1'b1; wait_clk(Q);
        end
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        sda_m = 1'b1; wait_clk(Q);
    endtask

    task automatic clock_bit(input logic b, output logic r);
        sda_m = b;    wait_clk(Q);
        scl   = 1'b1; wait_clk(Q);
        r     = sda_line;
        wait_clk(Q);
        scl   = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(d[i], r);
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(mack, r);
    endtask

    initial begin
        logic       ack;
        logic       r;
        logic [7:0] d;

        wait_clk(3);
        check("rst_sda", sda_out, 1'b1);
        check("rst_rxd", rx_data, 16'h0000);
        check("rst_two", rx_two_bytes, 1'b0);
        check("rst_vld", rx_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_addr", addressed, 1'b0);
        rst = 1'b0;
        wait_clk(Q);

        // One-byte write
        bus_start();
        check("w1_busy", busy, 1'b1);
        write_byte(8'h84, ack); check("w1_aack", ack, 1'b0);
        check("w1_addressed", addressed, 1'b1);
        write_byte(8'h5A, ack); check("w1_dack", ack, 1'b0);
        bus_stop();
        check("w1_vcnt", vcnt, 1);
        check("w1_data", cap_data, 16'h005A);
        check("w1_two", cap_two, 1'b0);
        check("w1_busy_end", busy, 1'b0);
        check("w1_addr_end", addressed, 1'b0);

        // Two-byte write followed by a third byte that must be refused
        bus_start();
        write_byte(8'h84, ack); check("w2_aack", ack, 1'b0);
        write_byte(8'hBE, ack); check("w2_ack1", ack, 1'b0);
        write_byte(8'hEF, ack); check("w2_ack2", ack, 1'b0);
        write_byte(8'h11, ack); check("w2_ack3", ack, 1'b1);
        bus_stop();
        check("w2_vcnt", vcnt, 2);
        check("w2_data", cap_data, 16'hBEEF);
        check("w2_two", cap_two, 1'b1);

        // Two-byte read, master NACKs the second
        tx_data = 16'h1234; tx_two_bytes = 1'b1;
        bus_start();
        write_byte(8'h85, ack); check("r1_aack", ack, 1'b0);
        tx_data = 16'hFFFF;
        read_byte(1'b0, d); check("r1_b0", d, 8'h12);
        read_byte(1'b1, d); check("r1_b1", d, 8'h34);
        check("r1_rel", sda_out, 1'b1);
        check("r1_addressed", addressed, 1'b1);
        bus_stop();
        check("r1_vcnt", vcnt, 2);

        // Foreign address
        bus_start();
        write_byte(8'h86, ack); check("na_aack", ack, 1'b1);
        check("na_addressed", addressed, 1'b0);
        write_byte(8'h55, ack); check("na_dack", ack, 1'b1);
        check("na_busy", busy, 1'b1);
        bus_stop();
        check("na_busy_end", busy, 1'b0);
        check("na_vcnt", vcnt, 2);

        // Write then repeated START into a one-byte read
        tx_data = 16'h00C3; tx_two_bytes = 1'b0;
        bus_start();
        write_byte(8'h84, ack); check("rs_aack", ack, 1'b0);
        write_byte(8'h77, ack); check("rs_dack", ack, 1'b0);
        bus_start();
        check("rs_vcnt", vcnt, 3);
        check("rs_data", cap_data, 16'hEF77);
        check("rs_two", cap_two, 1'b0);
        check("rs_busy", busy, 1'b1);
        check("rs_addressed", addressed, 1'b0);
        write_byte(8'h85, ack); check("rs_raack", ack, 1'b0);
        read_byte(1'b1, d); check("rs_rd", d, 8'hC3);
        bus_stop();
        check("rs_vcnt_end", vcnt, 3);

        // Reset while the target is driving the data ACK
        bus_start();
        write_byte(8'h84, ack); check("rr_aack", ack, 1'b0);
        write_byte(8'h33, ack); check("rr_dack", ack, 1'b0);
        for (int i = 7; i >= 0; i--) begin
            d = 8'h44;
            clock_bit(d[i], r);
        end
        sda_m = 1'b1; wait_clk(Q);
        scl = 1'b1; wait_clk(Q / 2);
        check("rr_drive", sda_out, 1'b0);
        rst = 1'b1;
        #1;
        check("rr_sda", sda_out, 1'b1);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(Q);
        check("rr_busy", busy, 1'b0);
        check("rr_addressed", addressed, 1'b0);
        check("rr_rxd", rx_data, 16'h0000);
        check("rr_vcnt", vcnt, 3);

        // General call write
        bus_start();
        write_byte(8'h00, ack);
`ifdef I2C_TARGET_GCALL_EN
        check("gc_aack", ack, 1'b0);
        check("gc_flag", gcall, 1'b1);
        write_byte(8'h09, ack); check("gc_dack", ack, 1'b0);
        bus_stop();
        check("gc_vcnt", vcnt, 4);
        check("gc_data", cap_data, 16'h0009);
        check("gc_flag_end", gcall, 1'b0);
`else
        check("gc_aack", ack, 1'b1);
        check("gc_addressed", addressed, 1'b0);
        write_byte(8'h09, ack); check("gc_dack", ack, 1'b1);
        bus_stop();
        check("gc_vcnt", vcnt, 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) responder for the same bus as the team's I2C master. It uses the 16-bit data and 1/2-byte transfer conventions.
- It oversamples SCL/SDA with the system clock and detects START, repeated START and STOP. It matches a fixed 7-bit address, ACKs it, then captures write bytes or returns read bytes.
- It sits behind the open-drain pad logic; sda_out=0 pulls the line low, sda_out=1 releases it.

Parameters:
- ADDR, 7'h42, own 7-bit target address.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock; at least 8x the SCL frequency.
- rst  input  1  asynchronous, active-high reset.
- scl_in  input  1  bus SCL level.
- sda_in  input  1  bus SDA level.
- sda_out  output  1  0 = drive SDA low, 1 = release.
- tx_data  input  16  read-return data, latched at address ACK.
- tx_two_bytes  input  1  1 = return [15:8] then [7:0]; 0 = return [7:0] only. Latched with tx_data.
- rx_data  output  16  write data; the last byte received sits in [7:0].
- rx_two_bytes  output  1  1 = rx_data holds 2 bytes, 0 = 1 byte; valid with rx_valid.
- rx_valid  output  1  one-clk pulse at STOP/repeated START closing a write of 1 or more bytes.
- busy  output  1  high from START to STOP.
- addressed  output  1  high from address ACK to STOP/repeated START.

Behaviour:
- Reset values: sda_out=1, rx_data=0, rx_two_bytes=0, rx_valid=0, busy=0, addressed=0, state=IDLE.
- Reset mid-transfer: SDA is released immediately and no rx_valid is issued.
- Synchronize scl/sda through SYNC_STAGES flops, then register once more for edge detection.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are checked in every state and take priority.
- Bits are sampled on the synchronized SCL rising edge.
- sda_out changes only on the cycle after the synchronized SCL falling edge is detected.
- Bit counter is 3 bits, counts 7 down to 0, MSB first.
- States and transitions:
  - IDLE: on START -> ADDR, busy=1.
  - ADDR: shift 8 bits (7 address bits + rw). On address match (or general call, see Optional Feature): go to ACK_ADDR, drive SDA low for one SCL low-high-low period, latch tx_data/tx_two_bytes, set addressed=1. On mismatch -> WAIT_STOP with SDA released.
  - ACK_ADDR: at the ACK-clock falling edge, rw=0 -> RX_BYTE with SDA released; rw=1 -> TX_BYTE, driving the first data bit.
  - RX_BYTE: shift 8 bits. If fewer than 2 bytes have been received this transfer, go to ACK_RX, ACK, and update rx_data <= {rx_data[7:0], byte}. Otherwise (a third or later byte) NACK and go to WAIT_STOP; the byte is discarded.
  - ACK_RX: -> RX_BYTE.
  - TX_BYTE: drive ~bit as sda_out polarity, i.e. sda_out = data bit. Release SDA after bit 0, then go to ACK_TX.
  - ACK_TX: sample the master's ACK on SCL rise. ACK (0) with a byte remaining -> TX_BYTE. ACK with no byte remaining -> TX_BYTE sending 8'hFF (SDA released). NACK (1) -> WAIT_STOP.
  - WAIT_STOP: SDA released and SCL ignored until START or STOP.
- On STOP: if write bytes were received, pulse rx_valid; rx_two_bytes = (count==2). Then -> IDLE with busy=0, addressed=0, SDA released.
- On repeated START: same rx_valid rule as STOP, then -> ADDR with busy=1.
- START/STOP while driving SDA: release on the same cycle the condition is detected.
- The target never stretches SCL.

Optional Feature:
- Macro: I2C_TARGET_GCALL_EN.
- Defined: address 7'h00 with rw=0 is ACKed and received exactly like an own-address write. The extra output port gcall (1 bit) is set with addressed and cleared with it.
- Undefined: address 7'h00 is treated as a mismatch and the gcall port does not exist.

Decomposition:
- Shared package i2c_pkg: state encoding localparams, and the constants GCALL_ADDR=7'h00, ACK=1'b0, NACK=1'b1.
- One sub-module, i2c_bus_sync: synchronizer plus registered edge detection. Outputs scl_rise, scl_fall, start_det, stop_det, sda_s.

Test Plan:
- 1-byte write: START, 0x84 (0x42,w), data 0x5A, STOP -> ACKs on the address and data bytes; rx_valid pulse; rx_data[7:0]=0x5A; rx_two_bytes=0.
- 2-byte write, then a third byte: 0xBE, 0xEF, 0x11 -> bytes 1-2 ACKed, third byte NACKed; at STOP rx_data=0xBEEF, rx_two_bytes=1.
- Read with tx_data=0x1234, tx_two_bytes=1: master ACKs the first byte, NACKs the second -> bus sees 0x12, 0x34; SDA released afterwards.
- Address 0x43 write -> NACK; no rx_valid; addressed stays 0; busy falls at STOP.
- Write 0x77, then repeated START with address 0x42 read -> rx_valid pulse at the repeated START with rx_data[7:0]=0x77; read phase proceeds. Separately, assert rst mid-byte -> sda_out=1 in the same cycle.
- General call write of 0x09: with I2C_TARGET_GCALL_EN -> ACK, gcall=1, rx_valid. Without the macro -> NACK.
